// File: rtl/mem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_if
//   Word-wide data memory bus between the load/store sequencer (master) and
//   the data memory (slave).
//
//   mem_valid  master -> slave  bus request, held until mem_ready
//   mem_we     master -> slave  1 = write, 0 = read
//   mem_addr   master -> slave  word-aligned byte address
//   mem_wdata  master -> slave  write word
//   mem_rdata  slave -> master  read word, valid with mem_ready
//   mem_ready  slave -> master  completion of the current request
// ---------------------------------------------------------------------------
interface mem_access_ctrl_if;
   logic        mem_valid;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport master (
      output mem_valid, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_valid, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//   Multicycle load/store sequencer between the core memory stage and a
//   word-wide data memory bus. Loads and SW take one bus access; SB/SH do a
//   read-modify-write using the external byte/halfword stager. Each accepted
//   request produces exactly one resp_valid pulse; misaligned or unsupported
//   accesses and bus timeouts complete with resp_err.
//
//   clk, resetn          clock, synchronous active-low reset
//   req_*                core request (accepted only while req_ready)
//   resp_*               one-cycle completion pulse with load data / error
//   mem                  data memory bus (master side)
//   stg_data_in          captured read word to the stager
//   stg_write_data       latched store source value
//   stg_offset           latched byte offset addr[1:0]
//   stg_funct3           latched funct3
//   stg_load_data        stager output: extended load word
//   stg_store_data       stager output: merged store word
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned TO_WIDTH       = 9
) (
   input  logic                     clk,
   input  logic                     resetn,

   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [2:0]               req_funct3,
   input  logic [31:0]              req_addr,
   input  logic [31:0]              req_wdata,

   output logic                     resp_valid,
   output logic [31:0]              resp_rdata,
   output logic                     resp_err,

   mem_access_ctrl_if.master        mem,

   output logic [31:0]              stg_data_in,
   output logic [31:0]              stg_write_data,
   output logic [1:0]               stg_offset,
   output logic [2:0]               stg_funct3,
   input  logic [31:0]              stg_load_data,
   input  logic [31:0]              stg_store_data
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Counter value in the last allowed wait cycle; a cycle that ends here
   // without mem_ready aborts the access.
   localparam logic [TO_WIDTH-1:0] TO_LAST =
      (TIMEOUT_CYCLES == 0) ? '0 : TO_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [1:0]          state_q,  state_d;
   logic [31:0]         addr_q,   addr_d;
   logic [31:0]         wdata_q,  wdata_d;
   logic [2:0]          funct3_q, funct3_d;
   logic                we_q,     we_d;
   logic                err_q,    err_d;
   logic [31:0]         rdata_q,  rdata_d;
   logic [TO_WIDTH-1:0] to_cnt_q, to_cnt_d;

   logic req_legal;
   logic bus_active;
   logic timeout_hit;

   // Legality of the incoming request: supported funct3 for the direction
   // and natural alignment for halfword/word.
   always_comb begin
      // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
      req_legal = 1'b0;
      case (req_funct3)
         F3_B:    req_legal = 1'b1;
         F3_H:    req_legal = !req_addr[0];
         F3_W:    req_legal = (req_addr[1:0] == 2'b00);
         F3_BU:   req_legal = !req_we;
         F3_HU:   req_legal = !req_we && !req_addr[0];
         default: req_legal = 1'b0;
      endcase
   end

   assign bus_active  = (state_q == ST_READ) || (state_q == ST_WRITE);
   // mem_ready in the final cycle takes priority over the abort.
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && !mem.mem_ready && (to_cnt_q == TO_LAST);

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      funct3_d = funct3_q;
      we_d     = we_q;
      err_d    = err_q;
      rdata_d  = rdata_q;
      to_cnt_d = to_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               funct3_d = req_funct3;
               we_d     = req_we;
               err_d    = !req_legal;
               to_cnt_d = '0;
               if (!req_legal)
                  state_d = ST_RESP;
               else if (req_we && req_funct3 == F3_W)
                  state_d = ST_WRITE;
               else
                  state_d = ST_READ;   // loads and the read half of SB/SH
            end
         end

         ST_READ: begin
            if (mem.mem_ready) begin
               rdata_d  = mem.mem_rdata;
               to_cnt_d = '0;
               state_d  = we_q ? ST_WRITE : ST_RESP;
            end else if (timeout_hit) begin
               // SB/SH abort here too, so memory is left untouched.
               err_d   = 1'b1;
               state_d = ST_RESP;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end

         ST_WRITE: begin
            if (mem.mem_ready) begin
               state_d = ST_RESP;
            end else if (timeout_hit) begin
               err_d   = 1'b1;
               state_d = ST_RESP;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end

         default: begin   // ST_RESP
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (!resetn) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         funct3_q <= '0;
         we_q     <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         to_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         funct3_q <= funct3_d;
         we_q     <= we_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
         to_cnt_q <= to_cnt_d;
      end
   end

   // Bus outputs are pure functions of registered state, so they cannot move
   // while a request waits for mem_ready.
   assign mem.mem_valid = bus_active;
   assign mem.mem_we    = (state_q == ST_WRITE);
   assign mem.mem_addr  = bus_active ? {addr_q[31:2], 2'b00} : '0;
   // SW writes the source word directly; SB/SH write the stager's merge of
   // the captured read word, which is stable because its inputs are latched.
   assign mem.mem_wdata = (state_q != ST_WRITE) ? '0 :
                          (funct3_q == F3_W)    ? wdata_q : stg_store_data;

   assign req_ready  = (state_q == ST_IDLE);
   assign resp_valid = (state_q == ST_RESP);
   assign resp_err   = (state_q == ST_RESP) && err_q;
   // rdata_q is written on the edge into RESP, so the stager output built
   // from it is settled for the whole RESP cycle.
   assign resp_rdata = ((state_q == ST_RESP) && !err_q && !we_q) ? stg_load_data : '0;

   assign stg_data_in    = rdata_q;
   assign stg_write_data = wdata_q;
   assign stg_offset     = addr_q[1:0];
   assign stg_funct3     = funct3_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Multicycle load/store sequencer between the core's memory-stage request and the word-wide data memory bus.
- Issues word-aligned bus reads and writes. For SB/SH it performs read-modify-write.
- Feeds the byte/halfword stager (data_in, write_data, address_offset, funct3) and consumes its load_data/store_data outputs.
- Returns one response per request and flags misalignment, unsupported funct3 and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 256, maximum cycles mem_valid stays asserted without mem_ready before abort; 0 disables the timeout
TO_WIDTH, 9, width of the timeout counter; must satisfy 2^TO_WIDTH > TIMEOUT_CYCLES

Ports:
clk  in  1  single clock; all state updates on rising edge
resetn  in  1  synchronous, active-low reset
req_valid  in  1  core request valid
req_ready  out  1  controller can accept; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V load/store funct3
req_addr  in  32  effective byte address
req_wdata  in  32  store source register value
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load result; 0 for stores and errors
resp_err  out  1  misaligned, unsupported or timed out; valid with resp_valid
mem_valid  out  1  bus request
mem_we  out  1  bus write enable
mem_addr  out  32  word-aligned bus address
mem_wdata  out  32  bus write word
mem_rdata  in  32  bus read word; sampled when mem_valid && mem_ready
mem_ready  in  1  bus completion, any latency ≥ 0 cycles after mem_valid rises
stg_data_in  out  32  captured read word to stager
stg_write_data  out  32  latched req_wdata
stg_offset  out  2  latched addr[1:0]
stg_funct3  out  3  latched funct3
stg_load_data  in  32  stager extended load word
stg_store_data  in  32  stager merged store word

Behaviour:
- Reset (resetn=0 at an edge):
  - State goes to IDLE.
  - mem_valid=0, mem_we=0, resp_valid=0, resp_err=0.
  - resp_rdata=0, mem_addr=0, mem_wdata=0.
  - All latches (addr, wdata, funct3, we, rdata_q) and the timeout counter are cleared.
  - Reset mid-transaction aborts it silently: no response, and mem_valid is low from the next cycle.
- States: IDLE, READ, WRITE, RESP.
- Accept: in IDLE with req_valid=1, latch req_* and check legality.
  - Legal loads: funct3 000, 001, 010, 100, 101. Legal stores: funct3 000, 001, 010.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
  - Illegal or misaligned → RESP with resp_err=1 and no bus cycle.
  - Legal load → READ.
  - SB/SH → READ (read-modify-write).
  - SW → WRITE.
- READ:
  - mem_valid=1, mem_we=0, mem_addr={addr[31:2],2'b00}.
  - On mem_ready, capture mem_rdata into rdata_q.
  - Then go to RESP for a load, or to WRITE for SB/SH.
- WRITE:
  - mem_valid=1, mem_we=1, same aligned address.
  - mem_wdata = latched wdata for SW; stg_store_data for SB/SH (stable, since it is derived from registered values only).
  - On mem_ready → RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - For loads, resp_rdata is the stg_load_data value registered on entry to RESP.
- Bus signal stability: mem_valid, mem_addr, mem_we and mem_wdata stay constant while mem_valid=1 and mem_ready=0. mem_valid is deasserted in the cycle after mem_ready.
- Timeout:
  - The counter clears on entering READ/WRITE and increments each cycle with mem_ready=0.
  - When it reaches TIMEOUT_CYCLES, drop mem_valid and go to RESP with resp_err=1.
  - An SB/SH timeout in READ skips WRITE, so memory is unmodified.
  - If mem_ready arrives in the same cycle as the timeout, mem_ready wins.
- Latency with zero-wait memory (accept at cycle 0):
  - Load: resp_valid at cycle 2.
  - SW: resp_valid at cycle 2.
  - SB/SH: resp_valid at cycle 3.
  - Error: resp_valid at cycle 1.
- Back-to-back: the next request is accepted in the first IDLE cycle after RESP, so the minimum spacing is 3 cycles for loads.
- req_* inputs are ignored outside IDLE. mem_ready is ignored while mem_valid=0.
- stg_* outputs are driven from latches at all times. stg_data_in = rdata_q.

Test Plan:
- LW, addr 0x100, memory word 0xDEADBEEF, mem_ready immediate → mem_addr=0x100 for one cycle; resp_rdata=0xDEADBEEF, resp_err=0 at cycle 2.
- LB, addr 0x103, word 0x80FF7F01 → resp_rdata=0xFFFFFF80; LBU at the same address → 0x00000080.
- SB, addr 0x202, wdata 0x000000AA, old word 0x11223344, 3-cycle mem_ready delay on each access → read then write of 0x11AA3344; mem_valid/mem_addr stable during the waits; resp_valid once.
- LH addr 0x301 and SW addr 0x302 → resp_err=1 at cycle 1; mem_valid never asserted.
- TIMEOUT_CYCLES=4, SH with mem_ready held 0 → mem_valid high for exactly 4 cycles then low; resp_err=1; no write issued.
- resetn=0 during WRITE of SW → mem_valid=0 next cycle; no resp_valid; req_ready=1 after reset release.
